// File: rtl/ann_frame_loader.sv
// ann_frame_loader: ping-pong frame buffer feeding the drowsiness ANN.
// Define INPUT_CLAMP_EN to saturate stored samples at CLAMP_MAX.
module ann_frame_loader #(
    parameter int N_IN      = 30,
    parameter int DW        = 10,
    parameter int CLAMP_MAX = 1000
) (
    input  logic               Clock,
    input  logic               Rst,
    input  logic [DW-1:0]      s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    output logic [N_IN*DW-1:0] in_vec,
    output logic               start,
    input  logic               done,
    output logic               busy,
    output logic [9:0]         frame_cnt,
    output logic               err_short
);

    localparam int IW = $clog2(N_IN);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
    localparam logic [DW-1:0] CLAMP_W  = DW'(CLAMP_MAX);
`ifdef INPUT_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    logic [DW-1:0]      mem [2][N_IN];
    logic [IW-1:0]      idx;
    logic               wr_bank;
    logic               wr_full;
    logic               done_q;
    logic               done_rise;
    logic               accept;
    logic               swap;
    logic [DW-1:0]      wdata;
    logic [N_IN*DW-1:0] frame_flat;

    assign s_ready   = !wr_full;
    assign accept    = s_valid && !wr_full;
    assign swap      = wr_full && !busy;
    assign done_rise = done && !done_q;
    assign wdata     = (CLAMP_ON && (s_data > CLAMP_W)) ? CLAMP_W : s_data;

    // Sample storage carries no reset; contents are only observed after a full fill.
    always_ff @(posedge Clock) begin
        if (accept) begin
            mem[wr_bank][idx] <= wdata;
        end
    end

    always_comb begin
        frame_flat = '0;
        for (int i = 0; i < N_IN; i++) begin
            frame_flat[i*DW +: DW] = mem[wr_bank][i];
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            in_vec    <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            err_short <= 1'b0;
            idx       <= '0;
            wr_bank   <= 1'b0;
            wr_full   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done;
            start  <= swap;
            if (swap) begin
                wr_bank   <= ~wr_bank;
                in_vec    <= frame_flat;
                wr_full   <= 1'b0;
                busy      <= 1'b1;
                frame_cnt <= frame_cnt + 10'd1;
            end else if (done_rise && busy) begin
                busy <= 1'b0;
            end
            // accept and swap are mutually exclusive through wr_full
            if (accept) begin
                if (idx == LAST_IDX) begin
                    idx     <= '0;
                    wr_full <= 1'b1;
                end else if (s_last) begin
                    idx       <= '0;
                    err_short <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ann_frame_loader.sv
// Testbench for ann_frame_loader: frame-level model plus directed frames.
// Build with INPUT_CLAMP_EN to exercise the clamped variant.
module tb_ann_frame_loader;

    localparam int N    = 30;
    localparam int DW   = 10;
    localparam int CMAX = 1000;
    localparam int VW   = N * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [VW-1:0] in_vec;
    logic          start;
    logic          done = 1'b0;
    logic          busy;
    logic [9:0]    frame_cnt;
    logic          err_short;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ann_frame_loader #(.N_IN(N), .DW(DW), .CLAMP_MAX(CMAX)) dut (
        .Clock(clk), .Rst(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .in_vec(in_vec), .start(start),
        .done(done), .busy(busy), .frame_cnt(frame_cnt),
        .err_short(err_short)
    );

    function automatic void chk(string nm, logic [VW-1:0] act,
                                logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] clampf(logic [DW-1:0] d);
`ifdef INPUT_CLAMP_EN
        return (int'(d) > CMAX) ? DW'(CMAX) : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [DW-1:0] w(int i);
        return in_vec[i*DW +: DW];
    endfunction

    // Frame-level model: collect words into a frame, hold at most one
    // completed frame, hand it over whenever the detector is free.
    logic [DW-1:0] cur[$];
    logic [DW-1:0] full_q[$];
    bit            m_full  = 0;
    bit            m_busy  = 0;
    bit            m_start = 0;
    bit            m_err   = 0;
    bit            m_dq    = 0;
    logic [9:0]    m_cnt   = '0;
    logic [VW-1:0] m_vec   = '0;

    always @(posedge clk or negedge rst_n) begin : model
        bit acc, dr, st;
        if (!rst_n) begin
            cur.delete();
            full_q.delete();
            m_full = 0; m_busy = 0; m_start = 0;
            m_err = 0; m_dq = 0; m_cnt = '0; m_vec = '0;
        end else begin
            acc = s_valid && !m_full;
            dr  = done && !m_dq;
            st  = 0;
            if (m_full && !m_busy) begin
                for (int i = 0; i < N; i++) m_vec[i*DW +: DW] = full_q[i];
                m_full = 0;
                m_busy = 1;
                m_cnt  = m_cnt + 10'd1;
                st     = 1;
            end else if (dr && m_busy) begin
                m_busy = 0;
            end
            if (acc) begin
                cur.push_back(clampf(s_data));
                if (cur.size() == N) begin
                    full_q = cur;
                    cur.delete();
                    m_full = 1;
                end else if (s_last) begin
                    m_err = 1;
                    cur.delete();
                end
            end
            m_start = st;
            m_dq    = done;
        end
    end

    always @(negedge clk) begin
        chk("s_ready", VW'(s_ready), VW'(!m_full));
        chk("start", VW'(start), VW'(m_start));
        chk("busy", VW'(busy), VW'(m_busy));
        chk("frame_cnt", VW'(frame_cnt), VW'(m_cnt));
        chk("err_short", VW'(err_short), VW'(m_err));
        chk("in_vec", in_vec, m_vec);
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [DW-1:0] d, bit last);
        int n = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed %0b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_last = 1'b0;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_ready", VW'(s_ready), VW'(1));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_vec", in_vec, '0);
        rst_n = 1'b1;
        step(2);

        // frame of constant 200, detector idle
        for (int i = 0; i < N; i++) send(10'd200, 1'b0);
        chk("a_start_early", VW'(start), VW'(0));
        idle();
        step(1);
        chk("a_start", VW'(start), VW'(1));
        chk("a_busy", VW'(busy), VW'(1));
        chk("a_cnt", VW'(frame_cnt), VW'(1));
        chk("a_w0", VW'(w(0)), VW'(200));
        chk("a_w29", VW'(w(29)), VW'(200));
        chk("a_ready", VW'(s_ready), VW'(1));

        // second frame stalls behind the busy detector
        for (int i = 0; i < N; i++) send(DW'(i), 1'b0);
        idle();
        step(1);
        chk("b_stall", VW'(s_ready), VW'(0));
        chk("b_hold", VW'(w(3)), VW'(200));
        step(3);
        done = 1'b1;
        step(1);
        chk("b_free", VW'(busy), VW'(0));
        chk("b_nostart", VW'(start), VW'(0));
        step(1);
        chk("b_start", VW'(start), VW'(1));
        chk("b_w7", VW'(w(7)), VW'(7));
        chk("b_cnt", VW'(frame_cnt), VW'(2));

        // done held high: no release without a fresh rise
        for (int i = 0; i < N; i++) send(DW'(100 + i), 1'b0);
        idle();
        step(5);
        chk("c_stall", VW'(s_ready), VW'(0));
        chk("c_busy", VW'(busy), VW'(1));
        chk("c_cnt", VW'(frame_cnt), VW'(2));
        done = 1'b0;
        step(1);
        done = 1'b1;
        step(2);
        chk("c_start", VW'(start), VW'(1));
        chk("c_cnt3", VW'(frame_cnt), VW'(3));
        chk("c_w0", VW'(w(0)), VW'(100));
        done = 1'b0;
        step(1);
        done = 1'b1;
        step(1);
        chk("c_free", VW'(busy), VW'(0));
        done = 1'b0;
        step(1);
        done = 1'b1;
        step(2);
        chk("idle_rise_busy", VW'(busy), VW'(0));
        chk("idle_rise_cnt", VW'(frame_cnt), VW'(3));
        done = 1'b0;

        // short frame terminated on the 5th word
        for (int i = 0; i < 4; i++) send(DW'(40 + i), 1'b0);
        send(10'd44, 1'b1);
        idle();
        step(2);
        chk("s_err", VW'(err_short), VW'(1));
        chk("s_cnt", VW'(frame_cnt), VW'(3));
        for (int i = 0; i < N; i++) send(DW'(500 + i), 1'b0);
        idle();
        step(1);
        chk("d_start", VW'(start), VW'(1));
        chk("d_cnt", VW'(frame_cnt), VW'(4));
        chk("d_w29", VW'(w(29)), VW'(529));
        chk("d_err", VW'(err_short), VW'(1));

        // reset mid-frame while busy
        for (int i = 0; i < 12; i++) send(10'd9, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("r_vec", in_vec, '0);
        chk("r_busy", VW'(busy), VW'(0));
        chk("r_cnt", VW'(frame_cnt), VW'(0));
        chk("r_err", VW'(err_short), VW'(0));
        chk("r_ready", VW'(s_ready), VW'(1));
        step(2);
        rst_n = 1'b1;
        step(1);

        // fresh frame with out-of-range sample
        send(10'd1023, 1'b0);
        send(10'd999, 1'b0);
        for (int i = 2; i < N; i++) send(10'd5, 1'b0);
        idle();
        step(1);
        chk("e_start", VW'(start), VW'(1));
        chk("e_cnt", VW'(frame_cnt), VW'(1));
`ifdef INPUT_CLAMP_EN
        chk("e_w0", VW'(w(0)), VW'(1000));
`else
        chk("e_w0", VW'(w(0)), VW'(1023));
`endif
        chk("e_w1", VW'(w(1)), VW'(999));
        chk("e_w2", VW'(w(2)), VW'(5));
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ann_frame_loader.md
Name: ann_frame_loader

Overview:
Producer-side feeder for the drowsiness-detector ANN. It collects a serial stream of 10-bit feature samples into a ping-pong pair of frame buffers, each holding N_IN words. It presents one complete frame as a flat parallel input vector, pulses start, and waits for the detector's done before presenting the next frame. It replaces switch-driven constant vectors with real streamed data ahead of the detector's in1/Start inputs.

Parameters:
N_IN, 30, words per frame (detector input count)
DW, 10, bits per sample
CLAMP_MAX, 1000, upper sample limit used only when INPUT_CLAMP_EN is defined

Ports:
Clock  in  1  system clock, rising edge
Rst  in  1  asynchronous reset, active-low
s_data  in  DW  sample word
s_valid  in  1  sample valid
s_ready  out  1  loader can accept a sample
s_last  in  1  producer marks final word of a frame
in_vec  out  N_IN*DW  presented frame; word i at bits [i*DW +: DW]
start  out  1  one-cycle pulse: in_vec holds a new frame
done  in  1  detector done level; rising edge frees the presented frame
busy  out  1  presented frame is owned by the detector
frame_cnt  out  10  frames launched, wraps 1023→0
err_short  out  1  sticky: a frame ended early on s_last

Behaviour:
- Reset is asserted when Rst=0, asynchronously. All of the following clear: in_vec=0, start=0, busy=0, frame_cnt=0, err_short=0, word index=0, both bank-full flags=0, write bank=0, done-edge register=0. s_ready=1 out of reset. Reset mid-frame drops the partial frame and any pending frame.
- Transfer rule: a word is accepted on a rising edge when s_valid && s_ready. s_ready = !wr_full (combinational).
- Accepting a word writes it to write_bank[idx]. idx increments.
- On the N_IN-th word (idx==N_IN-1), idx returns to 0 and wr_full is set. s_last on that word is ignored.
- If s_last is accepted with idx<N_IN-1: the word is stored, the frame is discarded, idx returns to 0, err_short is set (sticky until reset), and wr_full is not set.
- Done edge: done_rise = done && !done_q. When done_rise && busy, busy clears on that edge. done_rise while !busy is ignored.
- Swap occurs on an edge where wr_full && !busy. The write bank toggles, in_vec takes the just-filled bank, wr_full clears, busy sets, frame_cnt increments, and start=1 for exactly the following cycle.
- Simultaneous done_rise and wr_full with busy=1: busy clears on that edge and the swap happens on the next edge.
- Minimum latency: last word accepted at edge k → swap at edge k+1 → start high in cycle k+1..k+2 → s_ready high again from edge k+1.
- Backpressure: while wr_full && busy, s_ready=0. Stalls are unbounded until done_rise.
- in_vec is stable from the swap until the next swap, and never changes while busy=1.
- start is registered. It is never asserted for two consecutive cycles.

Optional Feature:
INPUT_CLAMP_EN. When defined, an accepted sample greater than CLAMP_MAX (unsigned) is stored as CLAMP_MAX. When undefined, samples are stored unmodified. Handshake and timing are identical in both builds.

Test Plan:
- Reset, then stream 30 words of 200 with s_valid held high and done=0 → start pulses once 1 cycle after the 30th accept. Every in_vec word = 200. busy=1, frame_cnt=1, s_ready stays 1.
- Continue streaming a second frame of values 0..29 with done low → after the 30th word s_ready=0 and in_vec is still all 200. Raise done → 2 cycles later start pulses, in_vec word i = i, and frame_cnt=2.
- Hold done high across frames → no further release until done falls and rises again. A done rise while busy=0 has no effect.
- s_last on the 5th word of a frame → err_short=1, no start. The next 30 words form a valid frame and launch normally; err_short stays 1.
- Assert Rst low mid-frame at word 12 with busy=1 → all outputs return to reset values. A fresh 30-word frame then launches with frame_cnt=1.
- With INPUT_CLAMP_EN: word value 1023 is stored as 1000 and value 999 is stored unchanged. Without it, 1023 is stored as 1023.
